// File: rtl/jt900h_ramfetch.sv
// Byte-window prefetcher: keeps CB bytes from base onward, filled by 16-bit word fetches.
// A word is accepted on the edge where ram_rd and ram_ok are both high; wait states hold the request stable.
module jt900h_ramfetch #(
  parameter int CB = 4,
  parameter int AW = 24
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cen,
  input  logic [AW-1:0]   req_addr,
  input  logic            flush,
  output logic [AW-1:0]   ram_addr,
  output logic            ram_rd,
  input  logic            ram_ok,
  input  logic [15:0]     ram_dout,
  output logic [8*CB-1:0] dout,
  output logic [CB-1:0]   dout_ok,
  output logic            ram_rdy
);

  localparam int NW = $clog2(CB+1);

  logic [AW-1:0]   base, base_nx, d, fa;
  logic [NW-1:0]   n, n_nx;
  logic [8*CB-1:0] data_q, data_nx;
  logic            active;
  logic            acc;

  always_comb begin
    d        = req_addr - base;
    fa       = base + AW'(n);
    ram_rd   = active && (n < NW'(CB));
    ram_addr = {fa[AW-1:1], 1'b0};
    dout     = data_q;
    for (int i = 0; i < CB; i++) dout_ok[i] = NW'(i) < n;
    ram_rdy  = &dout_ok;
    acc      = ram_rd && ram_ok;
  end

  // Window changes take priority over acceptance, so a word landing on a moving window is dropped.
  always_comb begin
    base_nx = base;
    n_nx    = n;
    data_nx = data_q;
    if (flush || d >= AW'(CB)) begin
      base_nx = req_addr;
      n_nx    = '0;
    end else if (d != '0) begin
      base_nx = req_addr;
      data_nx = data_q >> {d, 3'b000};
      n_nx    = (AW'(n) > d) ? n - NW'(d) : '0;
    end else if (acc) begin
      for (int i = 0; i < CB; i++) begin
        if (NW'(i) == n)
          data_nx[8*i +: 8] = fa[0] ? ram_dout[15:8] : ram_dout[7:0];
        if (!fa[0] && NW'(i) == n + NW'(1))
          data_nx[8*i +: 8] = ram_dout[15:8];
      end
      n_nx = (!fa[0] && n < NW'(CB-1)) ? n + NW'(2) : n + NW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base   <= '0;
      n      <= '0;
      data_q <= '0;
      active <= 1'b0;
    end else if (cen) begin
      base   <= base_nx;
      n      <= n_nx;
      data_q <= data_nx;
      active <= 1'b1;
    end
  end

endmodule

// File: tb/tb_jt900h_ramfetch.sv
// Bench for jt900h_ramfetch: directed scenarios then random traffic against a window-level model.
module tb_jt900h_ramfetch;
  localparam int CB = 4;
  localparam int AW = 24;

  logic            clk = 1'b0;
  logic            rst_n, cen, flush, ram_rd, ram_ok, ram_rdy;
  logic [AW-1:0]   req_addr, ram_addr;
  logic [15:0]     ram_dout;
  logic [8*CB-1:0] dout;
  logic [CB-1:0]   dout_ok;

  int n_tests = 0;
  int n_fail  = 0;

  logic [AW-1:0] m_base;
  int            m_n;
  bit            m_started;

  always #5 clk = ~clk;

  function automatic logic [7:0] mem(input logic [AW-1:0] a);
    return (a[7:0] * 8'd7) ^ a[15:8] ^ a[23:16] ^ 8'hA5;
  endfunction

  assign ram_dout = {mem(ram_addr + 24'd1), mem(ram_addr)};

  jt900h_ramfetch #(.CB(CB), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .req_addr(req_addr), .flush(flush),
    .ram_addr(ram_addr), .ram_rd(ram_rd), .ram_ok(ram_ok), .ram_dout(ram_dout),
    .dout(dout), .dout_ok(dout_ok), .ram_rdy(ram_rdy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_model();
    logic [AW-1:0] fa;
    fa = m_base + AW'(m_n);
    check("ram_rd", 32'(ram_rd), 32'(m_started && m_n < CB));
    if (m_started && m_n < CB) check("ram_addr", 32'(ram_addr), 32'({fa[AW-1:1], 1'b0}));
    check("dout_ok", 32'(dout_ok), 32'((1 << m_n) - 1));
    check("ram_rdy", 32'(ram_rdy), 32'(m_n == CB));
    for (int i = 0; i < m_n; i++)
      check("dout_byte", 32'(dout[8*i +: 8]), 32'(mem(m_base + AW'(i))));
  endtask

  task automatic step(input logic [AW-1:0] ra, input logic fl, input logic ok, input logic ce);
    logic [AW-1:0] d, fa, nb;
    int nn;
    req_addr = ra; flush = fl; ram_ok = ok; cen = ce;
    d  = ra - m_base;
    fa = m_base + AW'(m_n);
    nb = m_base;
    nn = m_n;
    if (ce) begin
      if (fl || d >= AW'(CB)) begin
        nb = ra; nn = 0;
      end else if (d != 0) begin
        nb = ra; nn = (m_n > int'(d)) ? m_n - int'(d) : 0;
      end else if (m_started && m_n < CB && ok) begin
        nn = fa[0] ? m_n + 1 : ((m_n + 2 > CB) ? CB : m_n + 2);
      end
    end
    @(posedge clk); #1;
    if (ce) begin
      m_base = nb; m_n = nn; m_started = 1'b1;
    end
    check_model();
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_rd"},   32'(ram_rd),   32'd0);
    check({tag, "_addr"}, 32'(ram_addr), 32'd0);
    check({tag, "_ok"},   32'(dout_ok),  32'd0);
    check({tag, "_rdy"},  32'(ram_rdy),  32'd0);
  endtask

  initial begin
    logic [AW-1:0] ra;
    logic          fl;
    int            r;
    rst_n = 1'b0; cen = 1'b0; flush = 1'b0; ram_ok = 1'b0; req_addr = '0;
    m_base = '0; m_n = 0; m_started = 1'b0;
    #3;
    check_reset("reset");
    @(negedge clk); rst_n = 1'b1;

    step(24'h0, 0, 0, 1);
    check("first_rd", 32'(ram_rd), 32'd1);
    check("first_addr", 32'(ram_addr), 32'd0);

    // aligned fill
    step(24'h100, 0, 1, 1); check("fill_a0", 32'(ram_addr), 32'h100);
    step(24'h100, 0, 1, 1); check("fill_a1", 32'(ram_addr), 32'h102);
    step(24'h100, 0, 1, 1); check("fill_rdy", 32'(ram_rdy), 32'd1);
    check("fill_dout", 32'(dout), {mem(24'h103), mem(24'h102), mem(24'h101), mem(24'h100)});

    // shift by one
    step(24'h101, 0, 0, 1);
    check("shift_ok", 32'(dout_ok), 32'b0111);
    check("shift_addr", 32'(ram_addr), 32'h104);
    step(24'h101, 0, 1, 1);
    check("shift_b3", 32'(dout[31:24]), 32'(mem(24'h104)));
    check("shift_rdy", 32'(ram_rdy), 32'd1);

    // odd fill
    step(24'h501, 0, 1, 1); check("odd_a0", 32'(ram_addr), 32'h500);
    step(24'h501, 0, 1, 1); check("odd_ok1", 32'(dout_ok), 32'b0001);
    check("odd_b0", 32'(dout[7:0]), 32'(mem(24'h501)));
    check("odd_a1", 32'(ram_addr), 32'h502);
    step(24'h501, 0, 1, 1); check("odd_ok2", 32'(dout_ok), 32'b0111);
    check("odd_a2", 32'(ram_addr), 32'h504);
    step(24'h501, 0, 1, 1); check("odd_ok3", 32'(dout_ok), 32'b1111);

    // flush and jump
    step(24'h501, 1, 1, 1); check("flush_ok", 32'(dout_ok), 32'd0);
    check("flush_addr", 32'(ram_addr), 32'h500);
    step(24'h200, 0, 1, 1); check("jump_addr", 32'(ram_addr), 32'h200);
    step(24'h200, 0, 1, 1);
    step(24'h201, 1, 1, 1); check("flush_shift_ok", 32'(dout_ok), 32'd0);
    check("flush_shift_addr", 32'(ram_addr), 32'h200);

    // wait states, then a request change during the wait
    step(24'h201, 0, 1, 1);
    for (int i = 0; i < 3; i++) begin
      step(24'h201, 0, 0, 1);
      check("wait_addr", 32'(ram_addr), 32'h202);
      check("wait_ok", 32'(dout_ok), 32'b0001);
    end
    step(24'h240, 0, 0, 1); check("wait_jump", 32'(ram_addr), 32'h240);
    step(24'h240, 0, 1, 1); check("wait_fill", 32'(dout_ok), 32'b0011);
    step(24'h999, 1, 1, 0);

    // reset mid-fill
    step(24'h600, 0, 1, 1);
    step(24'h600, 0, 1, 1);
    rst_n = 1'b0;
    #1;
    check_reset("midrst");
    m_base = '0; m_n = 0; m_started = 1'b0;
    @(negedge clk); rst_n = 1'b1;

    // wrap-around
    step(24'hFFFFFE, 0, 1, 1); check("wrap_a0", 32'(ram_addr), 32'hFFFFFE);
    step(24'hFFFFFE, 0, 1, 1); check("wrap_a1", 32'(ram_addr), 32'h000000);
    step(24'hFFFFFE, 0, 1, 1); check("wrap_rdy", 32'(ram_rdy), 32'd1);

    for (int k = 0; k < 3000; k++) begin
      r  = $urandom_range(0, 99);
      ra = m_base;
      fl = 1'b0;
      if (r < 10)      ra = m_base + AW'($urandom_range(1, CB-1));
      else if (r < 13) ra = AW'($urandom);
      else if (r < 15) ra = AW'($urandom_range(0, 7)) - 24'd4;
      else if (r < 17) ra = m_base + AW'(CB);
      else if (r < 19) fl = 1'b1;
      step(ra, fl, $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 85);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
